// File: rtl/prescaled_updown_counter.sv
// Up/down counter that steps once every DIV enabled clocks, with wrap or saturate
// at the limits, synchronous clear/load and a registered rollover pulse.
module prescaled_updown_counter #(
  parameter int unsigned DIV       = 50000000,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             DIR,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TICK,
  output logic             WRAP,
  output logic             AT_LIMIT
);

  localparam int unsigned       PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0]  MAX_VAL    = WIDTH'(MAX_COUNT);
  localparam bit                SAT        = (SATURATE != 0);

  logic [PW-1:0] presc;

  assign TICK     = EN && (presc == PRESC_LAST);
  assign AT_LIMIT = DIR ? (COUNT == MAX_VAL) : (COUNT == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc <= '0;
      COUNT <= '0;
      WRAP  <= 1'b0;
    end else if (CLR) begin
      presc <= '0;
      COUNT <= '0;
      WRAP  <= 1'b0;
    end else if (LOAD) begin
      presc <= '0;
      COUNT <= (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;
      WRAP  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (TICK) begin
        presc <= '0;
        // DIR only matters on the step edge; limits either wrap (with pulse) or hold
        if (DIR) begin
          if (COUNT < MAX_VAL) begin
            COUNT <= COUNT + 1'b1;
          end else if (!SAT) begin
            COUNT <= '0;
            WRAP  <= 1'b1;
          end
        end else begin
          if (COUNT != '0) begin
            COUNT <= COUNT - 1'b1;
          end else if (!SAT) begin
            COUNT <= MAX_VAL;
            WRAP  <= 1'b1;
          end
        end
      end else if (EN) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: three instances (DIV=4 wrap, DIV=4 saturate, DIV=1 wrap) share stimulus.
module tb_prescaled_updown_counter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       EN = 1'b0, DIR = 1'b0, CLR = 1'b0, LOAD = 1'b0;
  logic [3:0] LOAD_VAL = '0;

  logic [3:0] a_count, b_count, c_count;
  logic       a_tick, b_tick, c_tick;
  logic       a_wrap, b_wrap, c_wrap;
  logic       a_lim, b_lim, c_lim;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  prescaled_updown_counter #(.DIV(4), .WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .COUNT(a_count), .TICK(a_tick), .WRAP(a_wrap), .AT_LIMIT(a_lim));

  prescaled_updown_counter #(.DIV(4), .WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .COUNT(b_count), .TICK(b_tick), .WRAP(b_wrap), .AT_LIMIT(b_lim));

  prescaled_updown_counter #(.DIV(1), .WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_c (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .COUNT(c_count), .TICK(c_tick), .WRAP(c_wrap), .AT_LIMIT(c_lim));

  task automatic chk(input string tag, input int unsigned step, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, step, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_a_count", 0, 32'(a_count), 0);
    chk("rst_a_wrap", 0, 32'(a_wrap), 0);
    chk("rst_a_tick", 0, 32'(a_tick), 0);
    chk("rst_a_lim", 0, 32'(a_lim), 1);
    chk("rst_c_tick", 0, 32'(c_tick), 0);

    // Up count for 44 cycles
    RESET = 1'b1; EN = 1'b1; DIR = 1'b1;
    for (int unsigned i = 1; i <= 44; i++) begin
      cyc();
      chk("up_a_tick", i, 32'(a_tick), (i % 4 == 3) ? 1 : 0);
      chk("up_a_count", i, 32'(a_count), (i / 4) % 10);
      chk("up_a_wrap", i, 32'(a_wrap), (i == 40) ? 1 : 0);
      chk("up_b_count", i, 32'(b_count), (i / 4 > 9) ? 9 : i / 4);
      chk("up_b_wrap", i, 32'(b_wrap), 0);
      chk("up_b_lim", i, 32'(b_lim), (i >= 36) ? 1 : 0);
      chk("up_c_tick", i, 32'(c_tick), 1);
      chk("up_c_count", i, 32'(c_count), i % 10);
      chk("up_c_wrap", i, 32'(c_wrap), (i % 10 == 0) ? 1 : 0);
    end

    // Load clamps to MAX_COUNT; CLR beats LOAD
    LOAD = 1'b1; LOAD_VAL = 4'd13;
    cyc();
    chk("load_a", 0, 32'(a_count), 9);
    chk("load_b", 0, 32'(b_count), 9);
    chk("load_c", 0, 32'(c_count), 9);
    chk("load_a_wrap", 0, 32'(a_wrap), 0);
    CLR = 1'b1; LOAD_VAL = 4'd5;
    cyc();
    chk("clr_a", 0, 32'(a_count), 0);
    chk("clr_b", 0, 32'(b_count), 0);
    chk("clr_c", 0, 32'(c_count), 0);

    // Down count from zero
    CLR = 1'b0; LOAD = 1'b0; DIR = 1'b0;
    #1;
    chk("dn_a_lim0", 0, 32'(a_lim), 1);
    for (int unsigned i = 1; i <= 5; i++) begin
      cyc();
      chk("dn_a_tick", i, 32'(a_tick), (i == 3) ? 1 : 0);
      chk("dn_a_count", i, 32'(a_count), (i >= 4) ? 9 : 0);
      chk("dn_a_wrap", i, 32'(a_wrap), (i == 4) ? 1 : 0);
      chk("dn_b_count", i, 32'(b_count), 0);
      chk("dn_b_wrap", i, 32'(b_wrap), 0);
      chk("dn_b_lim", i, 32'(b_lim), 1);
      chk("dn_c_count", i, 32'(c_count), 10 - i);
      chk("dn_c_wrap", i, 32'(c_wrap), (i == 1) ? 1 : 0);
    end

    // Pause: prescaler holds its partial progress
    LOAD = 1'b1; LOAD_VAL = 4'd5;
    cyc();
    chk("ld5_a", 0, 32'(a_count), 5);
    LOAD = 1'b0; DIR = 1'b1;
    cyc(); cyc();
    chk("pre_pause_c", 0, 32'(c_count), 7);
    EN = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) begin
      cyc();
      chk("pause_a_tick", i, 32'(a_tick), 0);
      chk("pause_a_count", i, 32'(a_count), 5);
      chk("pause_c_tick", i, 32'(c_tick), 0);
      chk("pause_c_count", i, 32'(c_count), 7);
    end
    EN = 1'b1;
    #1;
    chk("resume_a_tick", 0, 32'(a_tick), 0);
    chk("resume_c_tick", 0, 32'(c_tick), 1);
    cyc();
    chk("resume_a_tick", 1, 32'(a_tick), 1);
    chk("resume_a_count", 1, 32'(a_count), 5);
    cyc();
    chk("resume_a_tick", 2, 32'(a_tick), 0);
    chk("resume_a_count", 2, 32'(a_count), 6);
    chk("resume_c_count", 2, 32'(c_count), 9);

    // Asynchronous reset mid-period with COUNT=5
    LOAD = 1'b1; LOAD_VAL = 4'd5;
    cyc();
    LOAD = 1'b0;
    cyc(); cyc();
    chk("pre_rst_a", 0, 32'(a_count), 5);
    RESET = 1'b0;
    #1;
    chk("arst_a_count", 0, 32'(a_count), 0);
    chk("arst_a_wrap", 0, 32'(a_wrap), 0);
    chk("arst_a_tick", 0, 32'(a_tick), 0);
    chk("arst_c_count", 0, 32'(c_count), 0);
    cyc();
    RESET = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      cyc();
      chk("post_rst_a_tick", i, 32'(a_tick), (i == 3) ? 1 : 0);
      chk("post_rst_a_count", i, 32'(a_count), (i == 4) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

Interface
REQ-001 The block SHALL have parameter DIV, default 50000000, meaning clock cycles per count step (legal range >= 1).
REQ-002 The block SHALL have parameter WIDTH, default 4, meaning COUNT width in bits (legal range 1..16).
REQ-003 The block SHALL have parameter MAX_COUNT, default 15, meaning terminal count value (legal range 1..2^WIDTH-1).
REQ-004 The block SHALL have parameter SATURATE, default 0, meaning limit behaviour: 0 = wrap at the limit, 1 = hold at the limit.
REQ-005 The block SHALL have port CLK, input, 1 bit, meaning the clock; the block is rising-edge triggered.
REQ-006 The block SHALL have port RESET, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-007 The block SHALL have port EN, input, 1 bit, meaning run when 1, pause when 0.
REQ-008 The block SHALL have port DIR, input, 1 bit, meaning count up when 1, count down when 0.
REQ-009 The block SHALL have port CLR, input, 1 bit, meaning synchronous clear.
REQ-010 The block SHALL have port LOAD, input, 1 bit, meaning synchronous load strobe.
REQ-011 The block SHALL have port LOAD_VAL, input, WIDTH bits, meaning the value to load.
REQ-012 The block SHALL have port COUNT, output, WIDTH bits, meaning the registered count value.
REQ-013 The block SHALL have port TICK, output, 1 bit, meaning the prescaler terminal pulse (combinational).
REQ-014 The block SHALL have port WRAP, output, 1 bit, meaning a registered one-cycle rollover pulse.
REQ-015 The block SHALL have port AT_LIMIT, output, 1 bit, meaning COUNT is at the limit for the current DIR (combinational).

Function
REQ-016 The prescaler SHALL be a counter of width max(1, clog2(DIV)) that runs 0..DIV-1 and advances only while EN=1.
REQ-017 TICK SHALL be 1 exactly in cycles where EN=1 and prescaler==DIV-1; on that edge the prescaler SHALL return to 0.
REQ-018 With DIV=1, TICK SHALL equal EN every cycle.
REQ-019 With EN=0, the prescaler and COUNT SHALL hold (pause, not restart); TICK SHALL be 0.
REQ-020 A count step SHALL occur on the rising edge ending a TICK cycle; step latency from EN rising to the first step SHALL be DIV cycles from a zero prescaler.
REQ-021 DIR SHALL be sampled only in the TICK cycle; a DIR change mid-period SHALL NOT disturb the prescaler.
REQ-022 Up step: COUNT<MAX_COUNT -> COUNT+1; COUNT==MAX_COUNT -> 0 if SATURATE=0, hold if SATURATE=1.
REQ-023 Down step: COUNT>0 -> COUNT-1; COUNT==0 -> MAX_COUNT if SATURATE=0, hold if SATURATE=1.
REQ-024 WRAP SHALL be 1 for exactly the one cycle following a wrapping step (aligned with the new COUNT), and 0 otherwise; it SHALL never assert when SATURATE=1.
REQ-025 AT_LIMIT SHALL be (DIR=1 and COUNT==MAX_COUNT) or (DIR=0 and COUNT==0).
REQ-026 Input priority per edge SHALL be CLR > LOAD > step; a lower-priority action coinciding with a higher one SHALL be discarded.
REQ-027 CLR=1 SHALL set COUNT=0 and prescaler=0 on the next edge, regardless of EN, with WRAP=0.
REQ-028 LOAD=1 SHALL set COUNT=min(LOAD_VAL, MAX_COUNT) and prescaler=0 on the next edge, regardless of EN, with WRAP=0.
REQ-029 COUNT SHALL never exceed MAX_COUNT under any input sequence.
REQ-030 All arithmetic SHALL be unsigned, with no overflow beyond WIDTH bits.

Reset
REQ-031 RESET=0 SHALL immediately (asynchronously) force COUNT=0, prescaler=0 and WRAP=0; TICK and AT_LIMIT follow combinationally.
REQ-032 RESET asserted mid-period SHALL discard partial prescaler progress; after release, the first step SHALL occur DIV cycles after the first edge with EN=1.
REQ-033 Release of RESET SHALL be synchronous-safe: no step on the releasing edge.

Verification
REQ-034 Parameters DIV=4, MAX_COUNT=9, SATURATE=0, with EN=1, DIR=1 for 44 cycles -> TICK every 4th cycle; COUNT goes 0..9, then 0; one WRAP pulse with COUNT=0.
REQ-035 Same parameters with DIR=0 from COUNT=0 -> after 4 cycles COUNT=9 and WRAP=1 for one cycle.
REQ-036 Parameter SATURATE=1, counting up to 9 -> COUNT holds 9, AT_LIMIT=1, WRAP never asserts.
REQ-037 LOAD=1, LOAD_VAL=13 (MAX_COUNT=9) -> COUNT=9 next cycle; CLR and LOAD together -> COUNT=0.
REQ-038 EN dropped after 2 prescaler cycles for 10 cycles, then raised -> the next TICK occurs 2 cycles later.
REQ-039 RESET pulsed low mid-period with COUNT=5 -> COUNT=0 immediately; the first TICK occurs 4 cycles after release.
